// File: rtl/inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// inst_prefetch_queue
//
// Decoupled instruction fetch front-end sitting just upstream of the IF/ID
// register. It issues sequential word fetches to a variable-latency
// instruction memory and buffers each returned word with its PC and PC+4 in a
// small FIFO. The decode stage pops entries with a valid/ready handshake, and
// taken branches, jumps and jr flush everything through redirect.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        synchronous active-high reset
//   redirect     flush the queue and restart fetching at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] are forced to zero)
//   mem_req      fetch request to instruction memory
//   mem_addr     word address of the outstanding request
//   mem_ready    memory returns mem_rdata for the current request this cycle
//   mem_rdata    instruction word, meaningful only when mem_req && mem_ready
//   out_valid    head entry valid
//   out_ready    consumer takes the head entry (low while decode stalls)
//   out_inst     head instruction
//   out_pc       head PC
//   out_pcadd4   head PC+4
//   level        number of occupied entries
// ---------------------------------------------------------------------------
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_ready,
    input  logic [31:0]                mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pcadd4,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        discard_addr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic [31:0]        inst_q   [DEPTH];
    logic [31:0]        pc_q     [DEPTH];
    logic [31:0]        pcadd4_q [DEPTH];

    logic               pop;
    logic               slot_free;
    logic               push;

    // A slot counts as free when the queue is not full or the head leaves
    // this very cycle, which keeps full-queue streaming at one per cycle.
    // Once raised in FETCH the request cannot drop again before acceptance,
    // because without a push the level can only shrink.
    // In DISCARD the stale request must stay up until memory answers it.
    always_comb begin
        pop       = out_valid && out_ready;
        slot_free = (level != FULL_LEVEL) || pop;
        mem_req   = !reset && ((state == DISCARD) || slot_free);
        mem_addr  = (state == DISCARD) ? discard_addr : fetch_pc;
        push      = mem_req && mem_ready && (state == FETCH) && !redirect;
    end

    // Head registers feed the outputs directly; zero while empty.
    always_comb begin
        out_valid  = (level != '0);
        out_inst   = out_valid ? inst_q[rd_ptr]   : 32'h0;
        out_pc     = out_valid ? pc_q[rd_ptr]     : 32'h0;
        out_pcadd4 = out_valid ? pcadd4_q[rd_ptr] : 32'h0;
    end

    // Control state: reset beats redirect, redirect beats normal flow.
    // A redirect that catches an unanswered request parks in DISCARD with the
    // stale address remembered, so mem_addr stays stable while fetch_pc
    // already points at the new target.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            fetch_pc     <= RESET_PC;
            discard_addr <= 32'h0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
        end else if (redirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            if (state == FETCH) begin
                if (mem_req && !mem_ready) begin
                    state        <= DISCARD;
                    discard_addr <= fetch_pc;
                end else begin
                    state <= FETCH;
                end
            end else begin
                state <= mem_ready ? FETCH : DISCARD;
            end
        end else begin
            if (state == DISCARD && mem_ready) begin
                state <= FETCH;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage needs no reset: out_valid masks anything not yet written.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_q[wr_ptr]   <= mem_rdata;
            pc_q[wr_ptr]     <= fetch_pc;
            pcadd4_q[wr_ptr] <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_queue
//
// Directed bench for inst_prefetch_queue. Inputs change on the falling edge,
// a small memory responder answers after mem_lat request cycles, and outputs
// are compared just after the inputs settle, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_inst_prefetch_queue;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pcadd4;
    logic [2:0]  level;

    int compared   = 0;
    int mismatched = 0;
    int mem_lat    = 1;
    int req_cycles = 0;

    inst_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pcadd4  (out_pcadd4),
        .level       (level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory contents: one fixed word at the reset vector, a recognisable
    // address-derived pattern everywhere else.
    function automatic logic [31:0] instFor(input logic [31:0] addr);
        if (addr == 32'h0000_3000)
            return 32'h2408_0001;
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's inputs, then let the memory model answer the request.
    task automatic applyStimulus(input logic rst, input logic rdr,
                                 input logic [31:0] rpc, input logic ordy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        out_ready   = ordy;
        #1;
        if (mem_req) begin
            req_cycles++;
            mem_ready = (req_cycles >= mem_lat);
        end else begin
            req_cycles = 0;
            mem_ready  = 1'b0;
        end
        mem_rdata = instFor(mem_addr);
        #1;
    endtask

    task automatic tick();
        logic accepted;
        accepted = mem_req && mem_ready;
        @(posedge clock);
        if (accepted)
            req_cycles = 0;
        @(negedge clock);
    endtask

    task automatic doReset(input logic ordy);
        applyStimulus(1'b1, 1'b0, 32'h0, ordy);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, ordy);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_pc", out_pc, 32'h0);
        tick();
    endtask

    initial begin
        // ---- zero-wait streaming after reset ----
        mem_lat = 1;
        doReset(1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c1_req", 32'(mem_req), 32'd1);
        checkOutput("c1_addr", mem_addr, 32'h0000_3000);
        checkOutput("c1_valid", 32'(out_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("c2_valid", 32'(out_valid), 32'd1);
        checkOutput("c2_pc", out_pc, 32'h0000_3000);
        checkOutput("c2_pcadd4", out_pcadd4, 32'h0000_3004);
        checkOutput("c2_inst", out_inst, 32'h2408_0001);
        checkOutput("c2_addr", mem_addr, 32'h0000_3004);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("stream_pc", out_pc, 32'h0000_3004 + 32'(4 * i));
            checkOutput("stream_addr", mem_addr, 32'h0000_3008 + 32'(4 * i));
            checkOutput("stream_level", 32'(level), 32'd1);
            tick();
        end

        // ---- consumer stall fills the queue, release drains in order ----
        doReset(1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (i == 9) begin
                checkOutput("full_level", 32'(level), 32'd4);
                checkOutput("full_req", 32'(mem_req), 32'd0);
                checkOutput("full_head", out_pc, 32'h0000_3000);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                checkOutput("full_pop_req", 32'(mem_req), 32'd1);
                checkOutput("full_pop_addr", mem_addr, 32'h0000_3010);
            end
            checkOutput("drain_pc", out_pc, 32'h0000_3000 + 32'(4 * i));
            checkOutput("drain_level", 32'(level), 32'd4);
            tick();
        end

        // ---- three-cycle memory, then redirect over a pending request ----
        mem_lat = 3;
        doReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("slow_req", 32'(mem_req), 32'd1);
            checkOutput("slow_addr", mem_addr, 32'h0000_3000);
            checkOutput("slow_valid", 32'(out_valid), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("slow_c4_valid", 32'(out_valid), 32'd1);
        checkOutput("slow_c4_pc", out_pc, 32'h0000_3000);
        checkOutput("slow_c4_inst", out_inst, 32'h2408_0001);
        checkOutput("slow_c4_addr", mem_addr, 32'h0000_3004);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("slow_c5_valid", 32'(out_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("slow_c6_valid", 32'(out_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("slow_c7_pc", out_pc, 32'h0000_3004);
        checkOutput("slow_c7_addr", mem_addr, 32'h0000_3008);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_3100, 1'b0);
        checkOutput("redir_level", 32'(level), 32'd1);
        checkOutput("redir_addr", mem_addr, 32'h0000_3008);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("disc_valid", 32'(out_valid), 32'd0);
        checkOutput("disc_level", 32'(level), 32'd0);
        checkOutput("disc_req", 32'(mem_req), 32'd1);
        checkOutput("disc_addr", mem_addr, 32'h0000_3008);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("post_redir_addr", mem_addr, 32'h0000_3100);
            checkOutput("post_redir_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // ---- redirect to the top of the address space, zero-wait memory ----
        mem_lat = 1;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        checkOutput("redir_pc", out_pc, 32'h0000_3100);
        checkOutput("redir_pcadd4", out_pcadd4, 32'h0000_3104);
        checkOutput("redir_inst", out_inst, 32'hA5A5_3100);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_c1_valid", 32'(out_valid), 32'd0);
        checkOutput("wrap_c1_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_c2_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_c2_pcadd4", out_pcadd4, 32'h0000_0000);
        checkOutput("wrap_c2_inst", out_inst, 32'h5A5A_FFFC);
        checkOutput("wrap_c2_addr", mem_addr, 32'h0000_0000);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_c3_pc", out_pc, 32'h0000_0000);
        checkOutput("wrap_c3_pcadd4", out_pcadd4, 32'h0000_0004);
        checkOutput("wrap_c3_addr", mem_addr, 32'h0000_0004);
        tick();

        // ---- reset with three entries queued and a request pending ----
        mem_lat = 1;
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        mem_lat = 3;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_level", 32'(level), 32'd3);
        checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
        checkOutput("pre_rst_addr", mem_addr, 32'h0000_300C);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_pc", out_pc, 32'h0);
        checkOutput("mid_rst_req", 32'(mem_req), 32'd1);
        checkOutput("mid_rst_addr", mem_addr, 32'h0000_3000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
